gate_ctrl: RTL and testbench
============================

GATE_CTRL -- requirements
Module: gate_ctrl

Interface
REQ-001 Parameter CAPACITY, default 12, maximum occupancy admitted; legal range 1..15.
REQ-002 Parameter TIMEOUT_CYC, default 200, cycles a gate may stay open without a count change.
REQ-003 Port clk, input, 1: sole clock, rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port req_in, input, 1: entry request, level, held until served.
REQ-006 Port req_out, input, 1: exit request, level, held until served.
REQ-007 Port count, input, 4: occupancy from the occupancy counter.
REQ-008 Port gate_in_open, output, 1: entry gate open command.
REQ-009 Port gate_out_open, output, 1: exit gate open command.
REQ-010 Port full, output, 1: registered, high while count >= CAPACITY.
REQ-011 Port deny, output, 1: one-cycle pulse when an entry request is refused.
REQ-012 Port timeout_err, output, 1: one-cycle pulse when a gate closes on timeout.
REQ-013 Port state_dbg, output, 2: current state encoding.

Function
REQ-014 States are IDLE=0, ENTRY=1, EXIT=2 and HOLD=3. Exactly one gate output is high in ENTRY or EXIT; both are low in IDLE and HOLD.
REQ-015 In IDLE, the block samples count into snap and resolves requests:
  - req_out only -> EXIT.
  - req_in only, full low -> ENTRY.
  - req_in only, full high -> deny pulse next cycle; stay IDLE.
REQ-016 When req_in and req_out are both high in IDLE, round-robin applies: the direction not served last wins. After reset, exit wins first. An entry refused for full counts as served.
REQ-017 A repeated deny pulse is issued once per 4 cycles while req_in is held with full high.
REQ-018 In ENTRY, count == snap+1 (mod 16) -> HOLD. Wrap 15->0 is treated as a valid increment.
REQ-019 In EXIT, count == snap-1 (mod 16) -> HOLD. A change in count in the wrong direction is ignored, and the gate stays open.
REQ-020 HOLD lasts exactly 2 cycles with both gates low, then -> IDLE. Requests are not sampled during HOLD.
REQ-021 The gate output rises on the cycle after the IDLE decision. Latency from request to gate is 1 cycle.
REQ-022 full is updated every cycle from count, with 1-cycle latency.
REQ-023 Timeout: if TIMEOUT_CYC cycles elapse in ENTRY/EXIT without a qualifying change -> HOLD, with timeout_err pulsed on the transition cycle.

Reset
REQ-024 On reset, registers take these values: state=IDLE; gate_in_open=0, gate_out_open=0; full=0; deny=0; timeout_err=0; snap=0; timer=0; round-robin=exit-next.
REQ-025 Reset asserted mid-ENTRY/EXIT closes the gate on the next edge, with no error pulse.

Configuration
REQ-026 Macro GATE_CTRL_TIMEOUT_EN: when defined, the timer and timeout_err are active per REQ-023.
REQ-027 Without GATE_CTRL_TIMEOUT_EN, gates wait indefinitely, timeout_err is tied 0 and no timer logic is generated.

Structure
REQ-028 Package gate_ctrl_pkg holds the gate_state_t enum, COUNT_W=4, HOLD_CYC=2 and DENY_GAP=4.
REQ-029 Sub-module gate_timer is a loadable down-counter with a clear input and an expired flag, instantiated only under GATE_CTRL_TIMEOUT_EN.

Verification
REQ-030 Stimulus: count=3, req_in pulse held. Response: gate_in_open=1 one cycle later; count->4 gives HOLD, then gate closes, then IDLE after 2 cycles.
REQ-031 Stimulus: count=12 (CAPACITY), req_in held 10 cycles. Response: full=1, gate_in_open never rises, deny pulses at cycles 1, 5 and 9.
REQ-032 Stimulus: req_in and req_out high together from reset, count=5. Response: EXIT served first; ENTRY is served next after HOLD.
REQ-033 Stimulus: ENTRY open, count held static for 200 cycles (macro defined). Response: gate closes, timeout_err=1 for one cycle, state_dbg=3.
REQ-034 Stimulus: EXIT open, count=0->15 (decrement wrap). Response: HOLD is accepted. Count 5->6 during EXIT is ignored.
REQ-035 Stimulus: reset asserted during ENTRY. Response: all outputs 0 at the next edge, state_dbg=0.

Source files
------------

// File: rtl/gate_ctrl_pkg.sv
// Shared types and constants for the gate controller.
package gate_ctrl_pkg;

  localparam int COUNT_W  = 4;
  localparam int HOLD_CYC = 2;
  localparam int DENY_GAP = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    EXIT  = 2'd2,
    HOLD  = 2'd3
  } gate_state_t;

endpackage

// File: rtl/gate_timer.sv
// Loadable down-counter with clear; expired is high once the count reaches zero.
module gate_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/gate_ctrl.sv
// Entry/exit gate sequencer with round-robin arbitration, capacity deny and optional
// open-gate timeout (enabled by defining GATE_CTRL_TIMEOUT_EN).
module gate_ctrl
  import gate_ctrl_pkg::*;
#(
  parameter int CAPACITY    = 12,
  parameter int TIMEOUT_CYC = 200
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_in,
  input  logic               req_out,
  input  logic [COUNT_W-1:0] count,
  output logic               gate_in_open,
  output logic               gate_out_open,
  output logic               full,
  output logic               deny,
  output logic               timeout_err,
  output logic [1:0]         state_dbg
);

  localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int GAP_W  = (DENY_GAP > 1) ? $clog2(DENY_GAP) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
  localparam logic [GAP_W-1:0]   GAP_LOAD  = GAP_W'(DENY_GAP - 1);
  localparam logic [COUNT_W-1:0] CAP       = COUNT_W'(CAPACITY);

  gate_state_t        state, state_nxt;
  logic [COUNT_W-1:0] snap, snap_nxt;
  logic [COUNT_W-1:0] snap_inc, snap_dec;
  logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
  logic [GAP_W-1:0]   gap, gap_nxt;
  logic               rr_exit_next, rr_nxt;
  logic               deny_nxt;

`ifdef GATE_CTRL_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);

  logic timer_load, timer_exp, tmo_nxt;

  gate_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (state == HOLD),
    .load     (timer_load),
    .load_val (TMR_LOAD),
    .expired  (timer_exp)
  );
`endif

  assign snap_inc = snap + 1'b1;
  assign snap_dec = snap - 1'b1;

  always_comb begin
    state_nxt = state;
    snap_nxt  = snap;
    hold_nxt  = hold_cnt;
    gap_nxt   = gap;
    rr_nxt    = rr_exit_next;
    deny_nxt  = 1'b0;
`ifdef GATE_CTRL_TIMEOUT_EN
    timer_load = 1'b0;
    tmo_nxt    = 1'b0;
`endif
    case (state)
      IDLE: begin
        snap_nxt = count;
        if (!req_in) begin
          gap_nxt = '0;
        end else if (gap != '0) begin
          gap_nxt = gap - 1'b1;
        end
        // Exit wins when alone or when it is exit's turn; a refused entry still counts as served.
        if (req_out && (!req_in || rr_exit_next)) begin
          state_nxt = EXIT;
          rr_nxt    = 1'b0;
          gap_nxt   = '0;
`ifdef GATE_CTRL_TIMEOUT_EN
          timer_load = 1'b1;
`endif
        end else if (req_in) begin
          rr_nxt = 1'b1;
          if (!full) begin
            state_nxt = ENTRY;
            gap_nxt   = '0;
`ifdef GATE_CTRL_TIMEOUT_EN
            timer_load = 1'b1;
`endif
          end else if (gap == '0) begin
            deny_nxt = 1'b1;
            gap_nxt  = GAP_LOAD;
          end
        end
      end
      ENTRY: begin
        if (count == snap_inc) begin
          state_nxt = HOLD;
          hold_nxt  = '0;
        end
`ifdef GATE_CTRL_TIMEOUT_EN
        else if (timer_exp) begin
          state_nxt = HOLD;
          hold_nxt  = '0;
          tmo_nxt   = 1'b1;
        end
`endif
      end
      EXIT: begin
        if (count == snap_dec) begin
          state_nxt = HOLD;
          hold_nxt  = '0;
        end
`ifdef GATE_CTRL_TIMEOUT_EN
        else if (timer_exp) begin
          state_nxt = HOLD;
          hold_nxt  = '0;
          tmo_nxt   = 1'b1;
        end
`endif
      end
      HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          state_nxt = IDLE;
          hold_nxt  = '0;
        end else begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      snap          <= '0;
      hold_cnt      <= '0;
      gap           <= '0;
      rr_exit_next  <= 1'b1;
      gate_in_open  <= 1'b0;
      gate_out_open <= 1'b0;
      full          <= 1'b0;
      deny          <= 1'b0;
    end else begin
      state         <= state_nxt;
      snap          <= snap_nxt;
      hold_cnt      <= hold_nxt;
      gap           <= gap_nxt;
      rr_exit_next  <= rr_nxt;
      gate_in_open  <= (state_nxt == ENTRY);
      gate_out_open <= (state_nxt == EXIT);
      full          <= (count >= CAP);
      deny          <= deny_nxt;
    end
  end

`ifdef GATE_CTRL_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= tmo_nxt;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

  assign state_dbg = state;

endmodule

// File: tb/tb_gate_ctrl.sv
// Directed bench for gate_ctrl: sequencing, round-robin, deny cadence, wrap, timeout and reset.
module tb_gate_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_in;
  logic       req_out;
  logic [3:0] count;
  logic       gate_in_open;
  logic       gate_out_open;
  logic       full;
  logic       deny;
  logic       timeout_err;
  logic [1:0] state_dbg;

  int tests = 0;
  int fails = 0;

  gate_ctrl #(.CAPACITY(12), .TIMEOUT_CYC(200)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_in        (req_in),
    .req_out       (req_out),
    .count         (count),
    .gate_in_open  (gate_in_open),
    .gate_out_open (gate_out_open),
    .full          (full),
    .deny          (deny),
    .timeout_err   (timeout_err),
    .state_dbg     (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset   = 1'b1;
    req_in  = 1'b0;
    req_out = 1'b0;
    count   = 4'd0;
    tick();
    tick();
    chk("rst_state", state_dbg, 0);
    chk("rst_gin", gate_in_open, 0);
    chk("rst_gout", gate_out_open, 0);
    chk("rst_full", full, 0);
    chk("rst_deny", deny, 0);
    chk("rst_tmo", timeout_err, 0);

    // Basic entry: count 3 -> 4
    reset  = 1'b0;
    count  = 4'd3;
    req_in = 1'b1;
    tick();
    chk("ent_state", state_dbg, 1);
    chk("ent_gin", gate_in_open, 1);
    chk("ent_gout", gate_out_open, 0);
    req_in = 1'b0;
    count  = 4'd4;
    tick();
    chk("ent_hold1", state_dbg, 3);
    chk("ent_gin_closed", gate_in_open, 0);
    tick();
    chk("ent_hold2", state_dbg, 3);
    tick();
    chk("ent_idle", state_dbg, 0);

    // Simultaneous requests from reset: exit first, then entry
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    count   = 4'd5;
    req_in  = 1'b1;
    req_out = 1'b1;
    tick();
    chk("rr_exit_first", state_dbg, 2);
    chk("rr_gout", gate_out_open, 1);
    chk("rr_gin_low", gate_in_open, 0);
    count = 4'd4;
    tick();
    chk("rr_hold_a", state_dbg, 3);
    tick();
    tick();
    chk("rr_idle", state_dbg, 0);
    tick();
    chk("rr_entry_next", state_dbg, 1);
    chk("rr_gin", gate_in_open, 1);
    req_in  = 1'b0;
    req_out = 1'b0;
    count   = 4'd5;
    tick();
    chk("rr_hold_b", state_dbg, 3);
    tick();
    tick();
    chk("rr_idle_b", state_dbg, 0);

    // Exit with 0 -> 15 wrap; wrong-direction change first
    count   = 4'd0;
    req_out = 1'b1;
    tick();
    chk("wrap_exit", state_dbg, 2);
    req_out = 1'b0;
    count   = 4'd1;
    tick();
    chk("wrap_wrongdir", state_dbg, 2);
    chk("wrap_gout_held", gate_out_open, 1);
    count = 4'd15;
    tick();
    chk("wrap_hold", state_dbg, 3);
    tick();
    tick();
    count   = 4'd5;
    req_out = 1'b1;
    tick();
    chk("exit5_state", state_dbg, 2);
    req_out = 1'b0;
    count   = 4'd6;
    tick();
    chk("exit_5to6_ignored", state_dbg, 2);
    count = 4'd4;
    tick();
    chk("exit_5to4_hold", state_dbg, 3);
    tick();
    tick();
    chk("exit_idle", state_dbg, 0);

    // Capacity: deny pulses at cycles 1, 5, 9
    count = 4'd12;
    tick();
    chk("full_set", full, 1);
    req_in = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("deny_c%0d", i), deny, ((i == 1) || (i == 5) || (i == 9)) ? 1 : 0);
      chk($sformatf("deny_gin_c%0d", i), gate_in_open, 0);
      chk($sformatf("deny_state_c%0d", i), state_dbg, 0);
    end
    req_in = 1'b0;
    count  = 4'd3;
    tick();
    chk("full_clear", full, 0);

    // Timeout behaviour
    count  = 4'd7;
    req_in = 1'b1;
    tick();
    chk("tmo_entry", state_dbg, 1);
    req_in = 1'b0;
`ifdef GATE_CTRL_TIMEOUT_EN
    repeat (199) tick();
    chk("tmo_still_open", state_dbg, 1);
    chk("tmo_no_err_yet", timeout_err, 0);
    tick();
    chk("tmo_state_hold", state_dbg, 3);
    chk("tmo_err", timeout_err, 1);
    chk("tmo_gin_closed", gate_in_open, 0);
    tick();
    chk("tmo_err_pulse", timeout_err, 0);
    tick();
    chk("tmo_idle", state_dbg, 0);
`else
    repeat (210) tick();
    chk("notmo_open", state_dbg, 1);
    chk("notmo_gin", gate_in_open, 1);
    chk("notmo_err", timeout_err, 0);
    count = 4'd8;
    tick();
    chk("notmo_hold", state_dbg, 3);
    tick();
    tick();
`endif

    // Reset during ENTRY
    count  = 4'd2;
    req_in = 1'b1;
    tick();
    chk("rstmid_entry", state_dbg, 1);
    reset  = 1'b1;
    req_in = 1'b0;
    tick();
    chk("rstmid_state", state_dbg, 0);
    chk("rstmid_gin", gate_in_open, 0);
    chk("rstmid_gout", gate_out_open, 0);
    chk("rstmid_tmo", timeout_err, 0);
    chk("rstmid_deny", deny, 0);
    chk("rstmid_full", full, 0);
    reset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
